// File: rtl/fanin_collector_pkg.sv
// Shared width helpers for the fan-in collector and its arbiter.
package fanin_collector_pkg;

    // Lane index width; a single-lane build still carries one tag bit.
    function automatic int unsigned lane_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fanin_collector_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
    import fanin_collector_pkg::*;
#(
    parameter  int unsigned NUM_LANES = 4,
    localparam int unsigned LANE_W    = lane_width(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    ptr,
    input  logic                 enable,
    output logic [NUM_LANES-1:0] gnt,
    output logic [LANE_W-1:0]    gnt_idx
);

    logic              found;
    int unsigned       cand;
    logic [LANE_W-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            cand     = (32'(ptr) + k) % NUM_LANES;
            cand_idx = LANE_W'(cand);
            if (enable && !found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fanin_collector.sv
// Merges NUM_LANES valid/ready producers into one stream via a round-robin
// arbiter and a tagged circular FIFO; each output beat carries its source lane.
module fanin_collector
    import fanin_collector_pkg::*;
#(
    parameter  int unsigned NUM_LANES  = 4,
    parameter  int unsigned DATA_W     = 8,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned LANE_W     = lane_width(NUM_LANES),
    localparam int unsigned OCC_W      = occ_width(FIFO_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LANES-1:0]          in_valid,
    input  logic [NUM_LANES*DATA_W-1:0]   in_data,
    output logic [NUM_LANES-1:0]          in_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [LANE_W-1:0]             out_lane,
    input  logic                          out_ready,
    output logic [OCC_W-1:0]              occupancy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    logic [LANE_W-1:0]    ptr;
    logic [LANE_W-1:0]    gnt_idx;
    logic [NUM_LANES-1:0] gnt;
    logic                 arb_en;
    logic                 push;
    logic                 pop;
    logic [DATA_W-1:0]    push_data;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     occ;
    fifo_entry_t          mem [FIFO_DEPTH];
    fifo_entry_t          head;

    // No full-bypass: grants depend only on occupancy, never on out_ready.
    assign arb_en = !reset && (occ != OCC_W'(FIFO_DEPTH));

    rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .enable  (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign in_ready  = gnt;
    assign push      = |gnt;
    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];
    assign out_data  = head.data;
    assign out_lane  = head.lane;
    assign occupancy = occ;

    always_comb begin
        push_data = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (gnt[i]) push_data = in_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                ptr    <= (gnt_idx == LANE_W'(NUM_LANES - 1)) ? '0 : gnt_idx + LANE_W'(1);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

    // Storage is left uninitialised; reset only clears the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fifo_entry_t'{lane: gnt_idx, data: push_data};
    end

endmodule

// File: tb/tb_fanin_collector.sv
// Directed bench for fanin_collector with a queue scoreboard and output monitor.
module tb_fanin_collector;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_lane;
    logic        out_ready;
    logic [2:0]  occupancy;

    fanin_collector #(.NUM_LANES(4), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb[$];
    int          left[4];
    logic [7:0]  nxt[4];
    logic [7:0]  stride[4];
    logic        reset_q;
    logic        ready_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_beat(input int lane, input int data);
        sb.push_back({8'(lane), 8'(data)});
    endtask

    task automatic start_lane(input int i, input logic [7:0] first, input int count,
                              input logic [7:0] step);
        left[i]   = count;
        nxt[i]    = first;
        stride[i] = step;
    endtask

    // Called at a negedge: records grants, advances producers after the edge, returns at next negedge.
    task automatic adv();
        logic [3:0] g;
        g = in_valid & in_ready;
        @(posedge clk);
        #1;
        reset     = reset_q;
        out_ready = ready_q;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                left[i]--;
                nxt[i] = nxt[i] + stride[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            in_valid[i]        = (left[i] != 0);
            in_data[i*8 +: 8]  = nxt[i];
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (sb.size() == 0 && !out_valid) break;
            adv();
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Output monitor: every accepted beat must match the scoreboard head.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got lane=%0d data=%0h expected no beat", out_lane, out_data);
            end else begin
                e = sb.pop_front();
                chk("out_lane", 32'(out_lane), 32'(e[15:8]));
                chk("out_data", 32'(out_data), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish by 50000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] fair_rdy [9];
        fair_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        clk = 1'b0; reset = 1'b1; out_ready = 1'b0; in_valid = '0; in_data = '0;
        reset_q = 1'b1; ready_q = 1'b1;
        for (int i = 0; i < 4; i++) start_lane(i, 8'h00, 0, 8'h00);
        @(posedge clk);
        @(negedge clk);

        // Reset held with every lane requesting.
        for (int i = 0; i < 4; i++) start_lane(i, 8'hA0 + 8'(i), 2, 8'h10);
        adv();
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_ready", 32'(in_ready), 32'd0);
            chk("reset_out_valid", 32'(out_valid), 32'd0);
            chk("reset_occupancy", 32'(occupancy), 32'd0);
            if (k == 2) reset_q = 1'b0;
            adv();
        end

        // Fairness: two rounds across all lanes.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) expect_beat(i, 8'hA0 + 8'(r * 16) + 8'(i));
        for (int k = 0; k < 9; k++) begin
            chk("fair_in_ready", 32'(in_ready), 32'(fair_rdy[k]));
            if (k == 0) chk("fair_out_valid_t0", 32'(out_valid), 32'd0);
            if (k == 1) chk("fair_out_valid_t1", 32'(out_valid), 32'd1);
            adv();
        end
        drain(20);

        // Backpressure until full, then release.
        ready_q = 1'b0;
        start_lane(2, 8'h10, 6, 8'h01);
        for (int d = 0; d < 6; d++) expect_beat(2, 8'h10 + 8'(d));
        adv();
        for (int k = 0; k < 4; k++) begin
            chk("bp_in_ready", 32'(in_ready), 32'b0100);
            adv();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_occupancy", 32'(occupancy), 32'd4);
        ready_q = 1'b1;
        adv();
        chk("pop_cycle_in_ready", 32'(in_ready), 32'd0);
        chk("pop_cycle_occupancy", 32'(occupancy), 32'd4);
        adv();
        chk("regrant_in_ready", 32'(in_ready), 32'b0100);
        chk("regrant_occupancy", 32'(occupancy), 32'd3);
        adv();
        chk("regrant2_in_ready", 32'(in_ready), 32'b0100);
        adv();
        chk("bp_done_in_ready", 32'(in_ready), 32'd0);
        drain(20);

        // Simultaneous push and pop at occupancy 2.
        ready_q = 1'b0;
        start_lane(1, 8'h20, 2, 8'h01);
        for (int d = 0; d < 5; d++) expect_beat(1, 8'h20 + 8'(d));
        adv();
        adv();
        adv();
        chk("pp_fill_occupancy", 32'(occupancy), 32'd2);
        ready_q = 1'b1;
        start_lane(1, 8'h22, 3, 8'h01);
        for (int k = 0; k < 4; k++) begin
            adv();
            chk("pp_occupancy", 32'(occupancy), 32'd2);
        end
        drain(20);

        // Nine beats on lane 3 wrap both FIFO pointers.
        start_lane(3, 8'h30, 9, 8'h01);
        for (int d = 0; d < 9; d++) expect_beat(3, 8'h30 + 8'(d));
        adv();
        drain(40);

        // Reset with three entries buffered.
        ready_q = 1'b0;
        start_lane(0, 8'h40, 3, 8'h01);
        for (int k = 0; k < 4; k++) adv();
        chk("pre_reset_occupancy", 32'(occupancy), 32'd3);
        reset_q = 1'b1;
        adv();
        adv();
        chk("mid_reset_occupancy", 32'(occupancy), 32'd0);
        chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_in_ready", 32'(in_ready), 32'd0);
        reset_q = 1'b0;
        ready_q = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_lane(i, 8'h50 + 8'(i), 1, 8'h01);
            expect_beat(i, 8'h50 + 8'(i));
        end
        adv();
        chk("post_reset_ptr0_grant", 32'(in_ready), 32'b0001);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
